// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - data-bus arbiter sharing one req/ack memory port between the CPU M stage and DMA
// One transaction in flight at a time; CPU is favoured until DMA has been passed over STARVE_LIMIT times.
module dbus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_byteen,
  output logic [31:0] dma_rdata,
  output logic        dma_done,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, CPU_XFER, DMA_XFER, DONE} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q;
  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_byteen_q;
  logic        cpu_done_q;
  logic        dma_done_q;
  logic [31:0] cpu_rdata_q;
  logic [31:0] dma_rdata_q;

  logic cpu_want;
  logic dma_want;
  logic dma_wins;

  // A master still seeing its done pulse has already been served.
  assign cpu_want = cpu_req & ~cpu_done_q;
  assign dma_want = dma_req & ~dma_done_q;
  assign dma_wins = dma_want & (~cpu_want | (starve_q == LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (dma_wins) begin
      starve_d = 4'd0;
    end else if (cpu_want) begin
      if (!dma_want) begin
        starve_d = 4'd0;
      end else if (starve_q != LIMIT) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_q     <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_byteen_q <= 4'd0;
      cpu_done_q   <= 1'b0;
      dma_done_q   <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      dma_rdata_q  <= 32'd0;
    end else begin
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_want || dma_want) begin
            starve_q  <= starve_d;
            mem_req_q <= 1'b1;
            if (dma_wins) begin
              mem_addr_q   <= dma_addr;
              mem_wdata_q  <= dma_wdata;
              mem_byteen_q <= dma_byteen;
              state_q      <= DMA_XFER;
            end else begin
              mem_addr_q   <= cpu_addr;
              mem_wdata_q  <= cpu_wdata;
              mem_byteen_q <= cpu_byteen;
              state_q      <= CPU_XFER;
            end
          end
        end
        CPU_XFER: begin
          if (mem_ack) begin
            cpu_rdata_q <= mem_rdata;
            cpu_done_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= DONE;
          end
        end
        DMA_XFER: begin
          if (mem_ack) begin
            dma_rdata_q <= mem_rdata;
            dma_done_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_byteen = mem_byteen_q;
  assign cpu_done   = cpu_done_q;
  assign dma_done   = dma_done_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign cpu_stall  = cpu_req & ~cpu_done_q;

endmodule
